// File: rtl/buffer.sv
// Receive-side gPTP timestamp buffer: one two-word record per frame type,
// written by the RX parser and drained word by word by the gPTP engine.
module buffer_slot #(
  parameter int   DATA_W   = 80,
  parameter logic TWO_WORD = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [DATA_W-1:0] wr_data2,
  input  logic              rd_en,
  output logic              occ,
  output logic [DATA_W-1:0] rd_word
);
  logic [DATA_W-1:0] word1, word2;
  logic              ptr;

  // Two-word slots hand out word1 first; everything else only ever returns word2.
  assign rd_word = (TWO_WORD && !ptr) ? word1 : word2;

  // A write after a same-edge read wins: new record, pointer back to word1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word1 <= '0;
      word2 <= '0;
      occ   <= 1'b0;
      ptr   <= 1'b0;
    end else if (wr_en) begin
      word1 <= wr_data1;
      word2 <= wr_data2;
      occ   <= 1'b1;
      ptr   <= 1'b0;
    end else if (rd_en) begin
      if (TWO_WORD && !ptr) begin
        ptr <= 1'b1;
      end else begin
        occ <= 1'b0;
        ptr <= 1'b0;
      end
    end
  end
endmodule

module buffer #(
  parameter int               DATA_W        = 80,
  parameter int               NSLOT         = 8,
  parameter logic [NSLOT-1:0] TWO_WORD_MASK = 8'h04
) (
  input  logic              clk,
  input  logic              reset,
  output logic [NSLOT-1:0]  rx_gptp_rd_vaild,
  output logic [DATA_W-1:0] rx_gptp_rd_data,
  input  logic [NSLOT-1:0]  rx_gptp_rd_addr,
  input  logic              rx_gptp_rd_ready,
  output logic              rx_rev_wr_ready,
  input  logic              rx_rev_wr_vaild,
  output logic              rx_rev_wr_v_ready,
  input  logic [NSLOT-1:0]  rx_rev_wr_addr,
  input  logic [DATA_W-1:0] rx_rev_wr_data1,
  input  logic [DATA_W-1:0] rx_rev_wr_data2
);
  logic [NSLOT-1:0]             wr_en, rd_en;
  logic [NSLOT-1:0][DATA_W-1:0] slot_word;
  logic [DATA_W-1:0]            rd_mux;
  logic                         accept, rd_hit;

  assign accept = rx_rev_wr_vaild && rx_rev_wr_v_ready && $onehot(rx_rev_wr_addr);
  assign rd_hit = rx_gptp_rd_ready && $onehot(rx_gptp_rd_addr)
                  && |(rx_gptp_rd_addr & rx_gptp_rd_vaild);
  assign wr_en  = accept ? rx_rev_wr_addr  : '0;
  assign rd_en  = rd_hit ? rx_gptp_rd_addr : '0;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    buffer_slot #(
      .DATA_W   (DATA_W),
      .TWO_WORD (TWO_WORD_MASK[i])
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[i]),
      .wr_data1 (rx_rev_wr_data1),
      .wr_data2 (rx_rev_wr_data2),
      .rd_en    (rd_en[i]),
      .occ      (rx_gptp_rd_vaild[i]),
      .rd_word  (slot_word[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NSLOT; i++)
      if (rx_gptp_rd_addr[i]) rd_mux |= slot_word[i];
  end

  // v_ready drops for exactly the cycle the wr_ready pulse is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_gptp_rd_data   <= '0;
      rx_rev_wr_ready   <= 1'b0;
      rx_rev_wr_v_ready <= 1'b0;
    end else begin
      if (rd_hit) rx_gptp_rd_data <= rd_mux;
      rx_rev_wr_ready   <= accept;
      rx_rev_wr_v_ready <= !accept;
    end
  end
endmodule

// File: tb/tb_buffer.sv
// Directed bench for the gPTP RX timestamp buffer.
module tb_buffer;
  localparam int DATA_W = 80;
  localparam int NSLOT  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NSLOT-1:0]  rd_vaild;
  logic [DATA_W-1:0] rd_data;
  logic [NSLOT-1:0]  rd_addr;
  logic              rd_ready;
  logic              wr_ready;
  logic              wr_vaild;
  logic              wr_v_ready;
  logic [NSLOT-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data1, wr_data2;

  int checks = 0;
  int errors = 0;
  logic [NSLOT-1:0] exp_vld;

  always #5 clk = ~clk;

  buffer dut (
    .clk               (clk),
    .reset             (reset),
    .rx_gptp_rd_vaild  (rd_vaild),
    .rx_gptp_rd_data   (rd_data),
    .rx_gptp_rd_addr   (rd_addr),
    .rx_gptp_rd_ready  (rd_ready),
    .rx_rev_wr_ready   (wr_ready),
    .rx_rev_wr_vaild   (wr_vaild),
    .rx_rev_wr_v_ready (wr_v_ready),
    .rx_rev_wr_addr    (wr_addr),
    .rx_rev_wr_data1   (wr_data1),
    .rx_rev_wr_data2   (wr_data2)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] w1(input int i);
    return {48'h123456789abc, 32'h1 << (4 * i)};
  endfunction
  function automatic logic [DATA_W-1:0] w2(input int i);
    return {48'h123456789abc, 32'h2 << (4 * i)};
  endfunction

  // Valid one-hot write; checks the busy cycle and the recovery cycle.
  task automatic wr(input logic [NSLOT-1:0] a, input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
    wr_vaild = 1'b1; wr_addr = a; wr_data1 = d1; wr_data2 = d2;
    @(negedge clk);
    wr_vaild = 1'b0;
    exp_vld |= a;
    chk("wr_pulse", wr_ready, 1);
    chk("wr_busy", wr_v_ready, 0);
    chk("wr_vld", rd_vaild, exp_vld);
    @(negedge clk);
    chk("wr_pulse_end", wr_ready, 0);
    chk("wr_vready_back", wr_v_ready, 1);
  endtask

  task automatic rd(input logic [NSLOT-1:0] a, input logic [DATA_W-1:0] exp_d, input logic [NSLOT-1:0] vld_after);
    rd_ready = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_ready = 1'b0;
    exp_vld = vld_after;
    chk("rd_data", rd_data, exp_d);
    chk("rd_vld", rd_vaild, exp_vld);
  endtask

  initial begin
    reset = 1'b0; rd_addr = '0; rd_ready = 1'b0; wr_vaild = 1'b0;
    wr_addr = '0; wr_data1 = '0; wr_data2 = '0; exp_vld = '0;
    #12;
    chk("rst_vld", rd_vaild, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_v_ready", wr_v_ready, 0);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_v_ready", wr_v_ready, 1);
    chk("post_rst_wr_ready", wr_ready, 0);

    // single-read slot
    wr(8'h01, w1(0), w2(0));
    rd(8'h01, 80'h123456789abc00000002, 8'h00);

    // two-word slot
    wr(8'h04, w1(2), w2(2));
    rd(8'h04, 80'h123456789abc00000100, 8'h04);
    rd(8'h04, 80'h123456789abc00000200, 8'h00);

    // fill all slots, then drain
    for (int i = 0; i < NSLOT; i++) wr(8'h01 << i, w1(i), w2(i));
    chk("all_full", rd_vaild, 8'hff);
    for (int i = 0; i < NSLOT; i++) begin
      if (i == 2) rd(8'h04, w1(2), exp_vld);
      rd(8'h01 << i, w2(i), exp_vld & ~(8'h01 << i));
    end
    chk("drain_last", rd_data, 80'h123456789abc20000000);
    chk("all_empty", rd_vaild, 8'h00);

    // non-one-hot write dropped, empty read holds data
    wr_vaild = 1'b1; wr_addr = 8'h03; wr_data1 = w1(1); wr_data2 = w2(1);
    @(negedge clk);
    wr_vaild = 1'b0;
    chk("bad_wr_pulse", wr_ready, 0);
    chk("bad_wr_vready", wr_v_ready, 1);
    chk("bad_wr_vld", rd_vaild, 8'h00);
    rd(8'h02, 80'h123456789abc20000000, 8'h00);

    // strobe during the busy cycle is ignored
    wr_vaild = 1'b1; wr_addr = 8'h08; wr_data1 = w1(3); wr_data2 = w2(3);
    @(negedge clk);
    wr_addr = 8'h40;
    @(negedge clk);
    wr_vaild = 1'b0;
    chk("busy_ign_vld", rd_vaild, 8'h08);
    chk("busy_ign_pulse", wr_ready, 0);
    exp_vld = 8'h08;
    rd(8'h08, w2(3), 8'h00);

    // same-edge write and read to one slot: read sees old, write lands
    wr(8'h01, 80'haaaa, 80'hbbbb);
    wr_vaild = 1'b1; wr_addr = 8'h01; wr_data1 = 80'hcccc; wr_data2 = 80'hdddd;
    rd_ready = 1'b1; rd_addr = 8'h01;
    @(negedge clk);
    wr_vaild = 1'b0; rd_ready = 1'b0;
    chk("same_rd_old", rd_data, 80'hbbbb);
    chk("same_vld", rd_vaild, 8'h01);
    chk("same_pulse", wr_ready, 1);
    @(negedge clk);
    rd(8'h01, 80'hdddd, 8'h00);

    // overwrite, then asynchronous reset mid-sequence
    wr(8'h10, 80'h1111, 80'h2222);
    wr(8'h10, 80'h3333, 80'h4444);
    wr(8'h20, 80'h5555, 80'h6666);
    rd(8'h10, 80'h4444, 8'h20);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_vld", rd_vaild, 8'h00);
    chk("mid_rst_data", rd_data, 0);
    chk("mid_rst_vready", wr_v_ready, 0);
    #10 reset = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
